// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: majority-vote oversampling, 5-8 data bits, five parity
// modes, 1/2 stop bits, valid/ready holding register. Optional break detect: UART_RX_CFG_BREAK_DET_EN.
module uart_rx_cfg #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_ser_in,
    input  logic [DIV_WIDTH-1:0] i_divisor,
    input  logic [1:0]           i_data_bits,
    input  logic [2:0]           i_parity_mode,
    input  logic                 i_stop_bits,
    output logic [7:0]           o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err,
    output logic                 o_rx_overrun,
    output logic                 o_rx_busy,
`ifdef UART_RX_CFG_BREAK_DET_EN
    output logic                 o_rx_break,
`endif
    output logic [2:0]           o_dbg_state
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;
    state_t r_state, w_state_n;

    logic                 r_sync1, r_sync2, r_sync3;
    logic [1:0]           r_samp;
    logic [DIV_WIDTH-1:0] r_pre, w_div_lim;
    logic [OS_W-1:0]      r_os;
    logic [2:0]           r_bit_cnt, w_last_bit;
    logic [1:0]           r_dbits;
    logic [2:0]           r_pmode;
    logic                 r_two;
    logic [7:0]           r_shift, w_data;
    logic                 r_parx, r_perr, r_ferr, r_fin;
    logic                 w_tick, w_line, w_fall, w_maj, w_start, w_hit, w_complete;
    logic                 w_par_en, w_hold_off, w_deliver;

    assign w_line     = r_sync2;
    assign w_fall     = r_sync3 & ~r_sync2;
    // The two previous tick samples plus the current line form the 3-sample vote window.
    assign w_maj      = (r_samp[1] & r_samp[0]) | (r_samp[1] & w_line) | (r_samp[0] & w_line);
    assign w_div_lim  = (i_divisor <= DIV_WIDTH'(1)) ? '0 : i_divisor - DIV_WIDTH'(1);
    assign w_tick     = (r_pre >= w_div_lim);
    assign w_par_en   = (r_pmode >= 3'd1) && (r_pmode <= 3'd4);
    assign w_last_bit = {1'b0, r_dbits} + 3'd4;
    assign w_data     = r_shift >> (2'd3 - r_dbits);
    assign w_start    = (r_state == S_IDLE) && w_fall && !w_hold_off;
    assign w_hit      = w_tick && (r_os == ((r_state == S_START) ? OS_HALF : OS_LAST));
    assign o_rx_busy  = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

`ifdef UART_RX_CFG_BREAK_DET_EN
    logic r_zero;
    assign w_hold_off = o_rx_break;
    assign w_deliver  = r_fin && !r_zero;
`else
    assign w_hold_off = 1'b0;
    assign w_deliver  = r_fin;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_n;
    end

    always_comb begin
        w_state_n  = r_state;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) w_state_n = S_START;
            S_START:  if (w_hit) w_state_n = w_maj ? S_IDLE : S_DATA;
            S_DATA:   if (w_hit && (r_bit_cnt == w_last_bit)) w_state_n = w_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (w_hit) w_state_n = S_STOP1;
            S_STOP1: begin
                if (w_hit) begin
                    if (r_two) begin
                        w_state_n = S_STOP2;
                    end else begin
                        w_state_n  = S_IDLE;
                        w_complete = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (w_hit) begin
                    w_state_n  = S_IDLE;
                    w_complete = 1'b1;
                end
            end
            default:  w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b1; r_sync2 <= 1'b1; r_sync3 <= 1'b1;
            r_samp <= 2'b11; r_pre <= '0; r_os <= '0; r_bit_cnt <= '0;
            r_dbits <= '0; r_pmode <= '0; r_two <= 1'b0; r_shift <= '0;
            r_parx <= 1'b0; r_perr <= 1'b0; r_ferr <= 1'b0; r_fin <= 1'b0;
`ifdef UART_RX_CFG_BREAK_DET_EN
            r_zero <= 1'b0;
`endif
        end else begin
            r_sync1 <= i_ser_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_pre   <= (w_start || w_tick) ? '0 : r_pre + DIV_WIDTH'(1);
            r_fin   <= w_complete;
            if (w_tick) r_samp <= {r_samp[0], w_line};
            if (w_start) begin
                r_dbits   <= i_data_bits;
                r_pmode   <= i_parity_mode;
                r_two     <= i_stop_bits;
                r_os      <= '0;
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_parx    <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
`ifdef UART_RX_CFG_BREAK_DET_EN
                r_zero    <= 1'b1;
`endif
            end else if ((r_state != S_IDLE) && w_tick) begin
                r_os <= w_hit ? '0 : r_os + OS_W'(1);
                if (w_hit) begin
                    case (r_state)
                        S_DATA: begin
                            r_shift   <= {w_maj, r_shift[7:1]};
                            r_parx    <= r_parx ^ w_maj;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        S_PARITY: begin
                            case (r_pmode)
                                3'd1:    r_perr <= ~(r_parx ^ w_maj);
                                3'd2:    r_perr <= r_parx ^ w_maj;
                                3'd3:    r_perr <= ~w_maj;
                                3'd4:    r_perr <= w_maj;
                                default: r_perr <= 1'b0;
                            endcase
                        end
                        S_STOP1, S_STOP2: r_ferr <= r_ferr | ~w_maj;
                        default: ;
                    endcase
`ifdef UART_RX_CFG_BREAK_DET_EN
                    if ((r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP1))
                        r_zero <= r_zero & ~w_maj;
`endif
                end
            end
        end
    end

    // Completed frames arrive one cycle after the final stop sample via r_fin.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_rx_data <= '0; o_rx_valid <= 1'b0; o_rx_parity_err <= 1'b0;
            o_rx_frame_err <= 1'b0; o_rx_overrun <= 1'b0;
`ifdef UART_RX_CFG_BREAK_DET_EN
            o_rx_break <= 1'b0;
`endif
        end else begin
            o_rx_overrun <= 1'b0;
            if (w_deliver) begin
                if (!o_rx_valid || i_rx_ready) begin
                    o_rx_data       <= w_data;
                    o_rx_parity_err <= r_perr;
                    o_rx_frame_err  <= r_ferr;
                    o_rx_valid      <= 1'b1;
                end else begin
                    o_rx_overrun <= 1'b1;
                end
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
`ifdef UART_RX_CFG_BREAK_DET_EN
            if (r_fin && r_zero)                      o_rx_break <= 1'b1;
            else if ((r_state == S_IDLE) && w_line)   o_rx_break <= 1'b0;
`endif
        end
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised, runtime-configurable UART receiver. It is the successor to the team's fixed 8-bit receiver and adds the following:
- internal oversampling baud-tick generator
- 3-sample majority-vote bit decision
- 5–8 data bits
- five parity modes
- 1 or 2 stop bits
- valid/ready output holding register with overrun detection

It sits between the async serial pin and a byte-stream consumer such as a FIFO or command parser.

Parameters:
OVERSAMPLE, 16, baud ticks per bit; even, 8..32.
DIV_WIDTH, 16, width of the divisor input.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
ser_in  in  1  async serial line; idles high.
divisor  in  DIV_WIDTH  clock cycles per oversample tick; 0 and 1 both mean every cycle.
data_bits  in  2  character length: 0=5, 1=6, 2=7, 3=8.
parity_mode  in  3  parity: 0=none, 1=odd, 2=even, 3=mark, 4=space; 5–7 are treated as none.
stop_bits  in  1  stop bits: 0=one, 1=two.
rx_data  out  8  received character, LSB-first, right-justified, unused MSBs zero.
rx_valid  out  1  rx_data and its error flags are valid.
rx_ready  in  1  consumer accepts the held character.
rx_parity_err  out  1  parity mismatch for the held character.
rx_frame_err  out  1  a stop bit was sampled 0 for the held character.
rx_overrun  out  1  one-cycle pulse: a frame completed while the holding register was full.
rx_busy  out  1  high from confirmed start edge until the final stop sample.

Behaviour:
- Reset values:
  - all outputs 0
  - synchroniser flops 1
  - FSM in IDLE
  - tick prescaler 0
- Synchroniser: 2-flop synchroniser on ser_in, followed by a 3-deep shift register clocked on ticks. The majority of those 3 bits is the sampled bit value.
- Tick generator: free-running counter that reloads at max(divisor,1)-1 and asserts tick for 1 cycle. The counter restarts at 0 on the falling-edge detect in IDLE.
- Config latching: data_bits, parity_mode and stop_bits are latched when the falling edge is detected. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. A per-bit tick counter os_cnt runs 0..OVERSAMPLE-1.
- IDLE → START: synchronised line goes 1→0. rx_busy rises on the next cycle.
- START: at os_cnt = OVERSAMPLE/2, take the majority vote.
  - Vote 1: false start; return to IDLE with no flag and rx_busy low.
  - Vote 0: go to DATA.
- DATA: sample at each mid-bit and shift in LSB-first. After N bits, go to PARITY if parity is enabled, otherwise STOP1.
- Parity check:
  - odd: XOR(data, p) must equal 1.
  - even: XOR(data, p) must equal 0.
  - mark: p must be 1.
  - space: p must be 0.
- STOP1 mid-sample: frame_err |= ~bit. Go to STOP2 if two stop bits are configured; otherwise the frame completes at this sample and the FSM goes to IDLE immediately (half-bit early, for resync).
- STOP2 mid-sample: frame_err |= ~bit; the frame completes and the FSM goes to IDLE.
- Frame complete:
  - If !rx_valid, or rx_valid && rx_ready in the same cycle: load rx_data and the error flags, and set rx_valid to 1 on the next cycle.
  - Otherwise: discard the new frame, keep the held frame unchanged, and pulse rx_overrun.
- Handshake:
  - rx_valid && rx_ready with no completion that cycle: rx_valid drops next cycle.
  - rx_data and the error flags stay stable while rx_valid is high.
- A frame with a frame error is still delivered, with rx_frame_err=1.
- Reset mid-frame aborts the frame with no output activity. The first frame after reset requires the line to be seen high first, because the synchroniser resets to 1.
- Latency: rx_valid rises 2 clock cycles after the tick of the final stop mid-sample.

Optional Feature:
Macro: UART_RX_CFG_BREAK_DET_EN.
- When defined:
  - adds output rx_break (1 bit, reset 0).
  - A frame whose data bits, parity bit (if enabled) and first stop bit are all 0 is a break. No character is delivered, and rx_valid is unaffected.
  - rx_break goes high at that completion and stays high until the line is sampled 1 in IDLE.
  - No new start is accepted until the line is sampled 1 in IDLE.
- When undefined:
  - no rx_break port.
  - an all-zero frame is delivered as data 0x00 with rx_frame_err=1.

Test Plan:
- 8N1 0xA5, divisor=4, OVERSAMPLE=16, rx_ready=1 → one rx_valid pulse, rx_data=0xA5, no error flags, rx_busy low after the stop mid-sample.
- 7E1 char 0x41 sent with a wrong parity bit of 1 → rx_data=0x41, rx_parity_err=1. Repeat with parity bit 0 → rx_parity_err=0.
- 5O2 char 0x15 with the second stop bit 0 → rx_data=0x15, rx_frame_err=1.
- Low glitch of 3 clock cycles on an idle line at divisor=4 → no rx_valid, rx_busy returns to 0 within 1 bit time, no error flags.
- rx_ready=0, send 0x11 then 0x22 → rx_valid=1 holding 0x11, one rx_overrun pulse at 0x22 completion. Then rx_ready=1 → 0x11 accepted, rx_valid falls.
- Feature enabled: hold line low for 2 frame times then release → rx_break=1, no rx_valid; rx_break clears after the line returns high. Feature disabled: same stimulus → rx_data=0x00 with rx_frame_err=1.
